matmul_engine: RTL and testbench
================================

MATMUL_ENGINE -- requirements
Module: matmul_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, element width in bits.
REQ-002 The block SHALL have parameter DIM, default 4, square matrix dimension (2..16).
REQ-003 The block SHALL have parameter ADDR_W, default 16, memory address width.
REQ-004 The block SHALL have parameters A_BASE, B_BASE and C_BASE, defaults 0, 16 and 32; these are the row-major base addresses of A, B and C.
REQ-005 The block SHALL have port i_clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port i_rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port i_start, input, 1 bit, level request to begin C = A x B.
REQ-008 The block SHALL have port o_busy, output, 1 bit, high while an operation is in progress.
REQ-009 The block SHALL have port o_done, output, 1 bit, one-cycle completion pulse.
REQ-010 The block SHALL have port o_mem_addr, output, ADDR_W bits, memory address.
REQ-011 The block SHALL have port o_mem_rd, output, 1 bit, read strobe.
REQ-012 The block SHALL have port o_mem_wr, output, 1 bit, write strobe.
REQ-013 The block SHALL have port o_mem_wdata, output, DATA_W bits, write data.
REQ-014 The block SHALL have port i_mem_rdata, input, DATA_W bits, read data, valid exactly one cycle after o_mem_rd.

Function
REQ-015 The FSM SHALL have the states IDLE, RD_A, RD_B, MAC, WR and DONE, with one cycle per state visit.
REQ-016 In IDLE, i_start=1 SHALL be accepted at a clock edge: i=j=k=0, accumulator cleared, next state RD_A.
REQ-017 In RD_A, the block SHALL assert o_mem_rd with o_mem_addr = A_BASE+i*DIM+k, then go to RD_B.
REQ-018 In RD_B, the block SHALL capture i_mem_rdata as a, assert o_mem_rd with o_mem_addr = B_BASE+k*DIM+j, then go to MAC.
REQ-019 In MAC, the block SHALL capture b and set acc += a*b (unsigned); if k<DIM-1 it SHALL increment k and go to RD_A, otherwise go to WR.
REQ-020 In WR, the block SHALL assert o_mem_wr with o_mem_addr = C_BASE+i*DIM+j and o_mem_wdata = the result per REQ-032 or REQ-033, clear acc, and set k=0.
REQ-021 After WR, j SHALL increment, wrapping to 0 with i incrementing; after element (DIM-1,DIM-1) the next state SHALL be DONE, otherwise RD_A.
REQ-022 The accumulator SHALL be 2*DATA_W+clog2(DIM) bits wide and SHALL never overflow.
REQ-023 In DONE, o_done SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-024 o_busy SHALL be 1 in every state except IDLE.
REQ-025 o_done SHALL be high in the cycle beginning DIM*DIM*(3*DIM+1) edges after the accept edge.
REQ-026 i_start SHALL be ignored outside IDLE; if i_start is held high, a new operation SHALL begin on the edge after DONE.
REQ-027 o_mem_rd and o_mem_wr SHALL never be high in the same cycle; both SHALL be 0 in IDLE and DONE.
REQ-028 o_mem_addr and o_mem_wdata SHALL be 0 whenever no strobe is asserted.

Reset
REQ-029 While i_rst_n=0, outputs SHALL be: state IDLE, o_busy=0, o_done=0, o_mem_rd=0, o_mem_wr=0, o_mem_addr=0, o_mem_wdata=0; i, j, k and acc SHALL be 0.
REQ-030 A reset mid-operation SHALL abort immediately with no further write; memory already written SHALL stay as is.
REQ-031 After reset release, the block SHALL wait in IDLE for i_start.

Configuration
REQ-032 With SATURATE_EN defined, a result with acc > 2^DATA_W-1 SHALL be written as all-ones; otherwise acc SHALL be written unchanged.
REQ-033 Without SATURATE_EN, the result written SHALL be acc[DATA_W-1:0] (modulo wrap).

Verification
REQ-034 Scenario: DIM=2, A=[1,2;3,4], B=[5,6;7,8] -> writes 19, 22, 43, 50 to addresses C_BASE..C_BASE+3; o_done 28 edges after accept.
REQ-035 Scenario: DIM=2, DATA_W=8, all A and B elements 255 -> each C element written as 255 with SATURATE_EN and as 2 without it.
REQ-036 Scenario: DIM=4, A = identity, B = 1..16 -> C equals B; exactly 16 writes and 128 reads occur.
REQ-037 Scenario: i_start pulsed again in the third cycle after accept -> no restart; exactly one o_done; the write sequence is unchanged.
REQ-038 Scenario: i_rst_n driven low in the 10th cycle after accept -> all outputs 0 in the same cycle; no write follows; a restart then gives the correct full result.
REQ-039 Scenario: i_start held high -> back-to-back operations with one IDLE cycle between DONE and the next RD_A; o_busy low only in that IDLE cycle.

Source files
------------

// File: rtl/matmul_engine.sv
`default_nettype none
// ============================================================================
// Module   : matmul_engine
// Purpose  : Sequential DIM x DIM matrix multiplier, C = A x B, over a single
//            shared memory port. A, B and C live row-major at A_BASE, B_BASE
//            and C_BASE. Each C element costs 3*DIM+1 cycles: for each k an
//            RD_A / RD_B / MAC triple, then one WR.
// Ports    : i_clk        - clock, rising edge
//            i_rst_n      - asynchronous active-low reset
//            i_start      - level request to begin an operation (IDLE only)
//            o_busy       - high in every state except IDLE
//            o_done       - one-cycle completion pulse
//            o_mem_addr   - memory address (0 when no strobe)
//            o_mem_rd     - read strobe; data returns on the next cycle
//            o_mem_wr     - write strobe
//            o_mem_wdata  - write data (0 when no strobe)
//            i_mem_rdata  - read data, valid one cycle after o_mem_rd
// Options  : SATURATE_EN - when defined, results above 2^DATA_W-1 are
//            written as all-ones; otherwise the low DATA_W bits are written.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_engine #(
  parameter int DATA_W = 8,
  parameter int DIM    = 4,
  parameter int ADDR_W = 16,
  parameter int A_BASE = 0,
  parameter int B_BASE = 16,
  parameter int C_BASE = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
  // Sum of DIM products of two DATA_W-bit values cannot exceed this width.
  localparam int ACC_W = 2*DATA_W + $clog2(DIM);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DIM - 1);

  localparam logic [2:0] c_idle = 3'd0;
  localparam logic [2:0] c_rd_a = 3'd1;
  localparam logic [2:0] c_rd_b = 3'd2;
  localparam logic [2:0] c_mac  = 3'd3;
  localparam logic [2:0] c_wr   = 3'd4;
  localparam logic [2:0] c_done = 3'd5;

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [IDX_W-1:0]  r_i;
  logic [IDX_W-1:0]  r_j;
  logic [IDX_W-1:0]  r_k;
  logic [DATA_W-1:0] r_a;
  logic [ACC_W-1:0]  r_acc;
  logic [ADDR_W-1:0] w_addr_a;
  logic [ADDR_W-1:0] w_addr_b;
  logic [ADDR_W-1:0] w_addr_c;
  logic [DATA_W-1:0] w_result;

  assign w_addr_a = ADDR_W'(A_BASE) + ADDR_W'(r_i) * ADDR_W'(DIM) + ADDR_W'(r_k);
  assign w_addr_b = ADDR_W'(B_BASE) + ADDR_W'(r_k) * ADDR_W'(DIM) + ADDR_W'(r_j);
  assign w_addr_c = ADDR_W'(C_BASE) + ADDR_W'(r_i) * ADDR_W'(DIM) + ADDR_W'(r_j);

`ifdef SATURATE_EN
  assign w_result = (r_acc > {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}}) ?
                    {DATA_W{1'b1}} : r_acc[DATA_W-1:0];
`else
  // Upper accumulator bits are intentionally discarded (modulo wrap).
  logic w_unused_acc_hi;
  assign w_unused_acc_hi = ^r_acc[ACC_W-1:DATA_W];
  assign w_result        = r_acc[DATA_W-1:0];
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:  w_next_state = i_start ? c_rd_a : c_idle;
      c_rd_a:  w_next_state = c_rd_b;
      c_rd_b:  w_next_state = c_mac;
      c_mac:   w_next_state = (r_k == c_last_idx) ? c_wr : c_rd_a;
      c_wr:    w_next_state = (r_i == c_last_idx && r_j == c_last_idx) ? c_done : c_rd_a;
      c_done:  w_next_state = c_idle;
      default: w_next_state = c_idle;
    endcase
  end

  // Outputs decode purely from state, so reset clears them in the same cycle.
  always_comb begin
    o_busy      = (r_state != c_idle);
    o_done      = 1'b0;
    o_mem_rd    = 1'b0;
    o_mem_wr    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (r_state)
      c_rd_a: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = w_addr_a;
      end
      c_rd_b: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = w_addr_b;
      end
      c_wr: begin
        o_mem_wr    = 1'b1;
        o_mem_addr  = w_addr_c;
        o_mem_wdata = w_result;
      end
      c_done:  o_done = 1'b1;
      default: ;
    endcase
  end

  // Indices, operand latch and accumulator. The A operand returns during
  // RD_B and is latched; the B operand returns during MAC and is used directly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_i   <= '0;
      r_j   <= '0;
      r_k   <= '0;
      r_a   <= '0;
      r_acc <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (i_start) begin
            r_i   <= '0;
            r_j   <= '0;
            r_k   <= '0;
            r_acc <= '0;
          end
        end
        c_rd_b: r_a <= i_mem_rdata;
        c_mac: begin
          r_acc <= r_acc + ACC_W'(r_a) * ACC_W'(i_mem_rdata);
          if (r_k != c_last_idx) begin
            r_k <= r_k + IDX_W'(1);
          end
        end
        c_wr: begin
          r_acc <= '0;
          r_k   <= '0;
          if (r_j == c_last_idx) begin
            r_j <= '0;
            r_i <= (r_i == c_last_idx) ? '0 : r_i + IDX_W'(1);
          end else begin
            r_j <= r_j + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matmul_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_engine
// Purpose  : Self-checking bench for matmul_engine. Matrix contents are
//            loaded into a behavioural memory, the expected C writes are
//            computed by plain matrix arithmetic and queued, and a monitor
//            pops and compares each write the DUT issues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matmul_engine;

  localparam int DATA_W = 8;
  localparam int DIM    = 4;
  localparam int ADDR_W = 16;
  localparam int A_BASE = 0;
  localparam int B_BASE = 16;
  localparam int C_BASE = 32;
  localparam int LAT    = DIM*DIM*(3*DIM+1);

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic              clk = 1'b0;
  logic              i_rst_n;
  logic              i_start;
  logic              o_busy;
  logic              o_done;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_rd;
  logic              o_mem_wr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata = '0;

  logic [DATA_W-1:0] mem [0:255];
  wr_t               exp_q[$];
  int                n_rd = 0;
  int                n_wr = 0;
  int                n_done = 0;
  int                compared = 0;
  int                mismatched = 0;

  matmul_engine #(
    .DATA_W (DATA_W),
    .DIM    (DIM),
    .ADDR_W (ADDR_W),
    .A_BASE (A_BASE),
    .B_BASE (B_BASE),
    .C_BASE (C_BASE)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_mem_addr  (o_mem_addr),
    .o_mem_rd    (o_mem_rd),
    .o_mem_wr    (o_mem_wr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural memory: one-cycle read latency, write on the clock edge.
  initial forever begin
    @(posedge clk);
    if (o_mem_rd) begin
      i_mem_rdata <= mem[o_mem_addr[7:0]];
      n_rd++;
    end
    if (o_mem_wr) begin
      mem[o_mem_addr[7:0]] <= o_mem_wdata;
      n_wr++;
    end
    if (o_done) n_done++;
  end

  // Monitor: bus invariants every cycle, scoreboard compare on each write.
  initial forever begin
    wr_t e;
    @(negedge clk);
    check("rd_wr_exclusive", longint'(o_mem_rd & o_mem_wr), 0);
    check("bus_zero_without_strobe",
          (!o_mem_rd && !o_mem_wr) ? longint'(o_mem_addr) + longint'(o_mem_wdata) : 0, 0);
    if (o_done) begin
      check("no_strobe_in_done", longint'(o_mem_rd | o_mem_wr), 0);
      check("busy_in_done", longint'(o_busy), 1);
    end
    if (o_mem_rd || o_mem_wr) check("addr_in_range", longint'(o_mem_addr < 256), 1);
    if (o_mem_wr) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", longint'(o_mem_addr), -1);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", longint'(o_mem_addr), e.addr);
        check("write_data", longint'(o_mem_wdata), e.data);
      end
    end
  end

  // mode 0: random, 1: A = identity / B = 1..DIM*DIM, 2: all ones-valued 255
  task automatic load(input int mode);
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        case (mode)
          1: begin
            mem[A_BASE + r*DIM + c] = (r == c) ? 8'd1 : 8'd0;
            mem[B_BASE + r*DIM + c] = 8'(r*DIM + c + 1);
          end
          2: begin
            mem[A_BASE + r*DIM + c] = 8'd255;
            mem[B_BASE + r*DIM + c] = 8'd255;
          end
          default: begin
            mem[A_BASE + r*DIM + c] = 8'($urandom_range(0, 255));
            mem[B_BASE + r*DIM + c] = 8'($urandom_range(0, 255));
          end
        endcase
      end
    end
  endtask

  // Reference: textbook matrix product, then saturate or wrap.
  task automatic push_expected();
    wr_t    e;
    longint sum;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        sum = 0;
        for (int k = 0; k < DIM; k++)
          sum += longint'(mem[A_BASE + r*DIM + k]) * longint'(mem[B_BASE + k*DIM + c]);
`ifdef SATURATE_EN
        e.data = (sum > 255) ? 255 : int'(sum);
`else
        e.data = int'(sum % 256);
`endif
        e.addr = C_BASE + r*DIM + c;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_done(input int pulse_at, input bit hold);
    int cyc = 0;
    while (!o_done && cyc < LAT + 50) begin
      @(posedge clk);
      #1;
      cyc++;
      if (pulse_at != 0 && cyc == pulse_at) i_start = 1'b1;
      else if (!hold) i_start = 1'b0;
      if (!o_done) check("busy_during_op", longint'(o_busy), 1);
    end
    check("done_latency", cyc, LAT);
  endtask

  task automatic do_op(input int pulse_at, input bit hold);
    int r0, w0, d0, ops;
    ops = hold ? 2 : 1;
    push_expected();
    if (hold) push_expected();
    @(negedge clk);
    check("idle_before_start", longint'(o_busy), 0);
    r0 = n_rd; w0 = n_wr; d0 = n_done;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) i_start = 1'b0;
    check("busy_after_accept", longint'(o_busy), 1);
    wait_done(pulse_at, hold);
    if (hold) begin
      @(posedge clk); #1;
      check("idle_gap_busy", longint'(o_busy), 0);
      check("idle_gap_done", longint'(o_done), 0);
      @(posedge clk); #1;
      check("back_to_back_busy", longint'(o_busy), 1);
      i_start = 1'b0;
      wait_done(0, 1'b0);
    end
    @(posedge clk); #1;
    check("done_one_cycle", longint'(o_done), 0);
    check("idle_after_done", longint'(o_busy), 0);
    check("read_count", n_rd - r0, ops * 2 * DIM * DIM * DIM);
    check("write_count", n_wr - w0, ops * DIM * DIM);
    check("done_count", n_done - d0, ops);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    int w0;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", longint'(o_busy), 0);
    check("rst_done", longint'(o_done), 0);
    check("rst_rd", longint'(o_mem_rd), 0);
    check("rst_wr", longint'(o_mem_wr), 0);
    check("rst_addr", longint'(o_mem_addr), 0);
    check("rst_wdata", longint'(o_mem_wdata), 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("wait_in_idle", longint'(o_busy), 0);

    repeat (3) begin
      load(0);
      do_op(0, 1'b0);
    end
    load(1);  do_op(0, 1'b0);   // identity x 1..16 -> C = B
    load(2);  do_op(0, 1'b0);   // all 255: saturate vs wrap
    load(0);  do_op(2, 1'b0);   // stray start pulse mid-operation
    load(0);  do_op(0, 1'b1);   // start held: back-to-back operations

    // Abort mid-operation with reset in the 10th cycle after accept.
    load(0);
    push_expected();
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("abort_busy", longint'(o_busy), 0);
    check("abort_done", longint'(o_done), 0);
    check("abort_rd", longint'(o_mem_rd), 0);
    check("abort_wr", longint'(o_mem_wr), 0);
    check("abort_addr", longint'(o_mem_addr), 0);
    check("abort_wdata", longint'(o_mem_wdata), 0);
    exp_q.delete();
    w0 = n_wr;
    repeat (4) @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_write_after_abort", n_wr - w0, 0);
    check("idle_after_abort", longint'(o_busy), 0);
    do_op(0, 1'b0);             // restart gives the full correct result

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
